// File: rtl/mem_access_stage_if.sv
// Data-memory request/acknowledge bus between the memory stage and the data memory.
// Bit 0 is the most significant bit of every vector.
interface mem_access_stage_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [0:31] dmem_addr;
  logic [0:3]  dmem_be;
  logic [0:31] dmem_wdata;
  logic [0:31] dmem_rdata;
  logic        dmem_ack;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    input  dmem_rdata, dmem_ack
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    output dmem_rdata, dmem_ack
  );
endinterface

// File: rtl/mem_access_stage.sv
// Memory stage: big-endian load/store against the data memory with stall and
// timeout, producing the registered MEM/WB bundle.
//   state | meaning
//   IDLE  | no access outstanding; an aligned memory op requests this cycle
//   WAIT  | request held, pipe frozen, counting toward TIMEOUT
module mem_access_stage #(
  parameter int TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [0:179]       exmem_in,
  input  logic               wb_regwrite,
  input  logic [0:4]         wb_dest,
  input  logic [0:31]        wb_value,
  mem_access_stage_if.master dmem,
  output logic               stall,
  output logic [0:106]       memwb_out
);

  typedef enum logic {IDLE, WAIT} state_t;

  state_t       state_q;
  logic [7:0]   cnt_q;
  logic [0:31]  wdata_q;
  logic [0:106] memwb_q;
  logic [0:106] memwb_d;

  logic [0:31] next_pc, alu_res, mem_val;
  logic [0:4]  dest_reg, rs2;
  logic        reg_write, mem_to_reg, mem_write, pc_to_reg, load_sign, trap;
  logic [0:1]  dsize, off;

  assign next_pc    = exmem_in[0:31];
  assign dest_reg   = exmem_in[64:68];
  assign alu_res    = exmem_in[69:100];
  assign pc_to_reg  = exmem_in[101];
  assign reg_write  = exmem_in[103];
  assign mem_to_reg = exmem_in[104];
  assign mem_write  = exmem_in[105];
  assign load_sign  = exmem_in[106];
  assign dsize      = exmem_in[107:108];
  assign mem_val    = exmem_in[142:173];
  assign rs2        = exmem_in[174:178];
  assign trap       = exmem_in[179];
  assign off        = alu_res[30:31];

  // opB, RegToPC and the leap fields belong to other stages
  logic unused_fields;
  assign unused_fields = ^{exmem_in[32:63], exmem_in[102], exmem_in[109:141]};

  logic is_store, is_load, is_mem, misaligned, access, in_wait;
  logic req, done_ack, timed_out, fwd, mis_flag, rw_out;
  logic [0:31] st_data, lane_wdata, load_data, ld_out;
  logic [0:3]  lane_be;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  assign is_store   = mem_write;
  assign is_load    = mem_to_reg & ~mem_write;
  assign is_mem     = is_store | is_load;
  assign misaligned = (dsize == 2'b01) ? off[1] : (dsize[0] ? (off != 2'b00) : 1'b0);
  assign access     = is_mem & ~trap & ~misaligned;
  assign in_wait    = (state_q == WAIT);

  // EX/MEM is frozen while waiting, so the request stays valid from the bundle
  assign req       = ~reset & (in_wait | access);
  assign done_ack  = req & dmem.dmem_ack;
  assign timed_out = in_wait & ~dmem.dmem_ack & (cnt_q == 8'(TIMEOUT));
  assign stall     = req & ~done_ack & ~timed_out;

  assign fwd     = wb_regwrite & (wb_dest == rs2) & (rs2 != 5'd0);
  assign st_data = fwd ? wb_value : mem_val;

  always_comb begin
    lane_be    = 4'b0000;
    lane_wdata = st_data;
    case (dsize)
      2'b00: begin
        lane_wdata   = {4{st_data[24:31]}};
        lane_be[off] = 1'b1;
      end
      2'b01: begin
        lane_wdata = {2{st_data[16:31]}};
        lane_be    = off[0] ? 4'b0011 : 4'b1100;
      end
      default: lane_be = 4'b1111;
    endcase
  end

  assign ld_byte = dmem.dmem_rdata[{off, 3'b000} +: 8];
  assign ld_half = off[0] ? dmem.dmem_rdata[16:31] : dmem.dmem_rdata[0:15];

  always_comb begin
    case (dsize)
      2'b00:   load_data = {{24{load_sign & ld_byte[7]}}, ld_byte};
      2'b01:   load_data = {{16{load_sign & ld_half[15]}}, ld_half};
      default: load_data = dmem.dmem_rdata;
    endcase
  end

  assign dmem.dmem_req   = req;
  assign dmem.dmem_we    = req & is_store;
  assign dmem.dmem_addr  = req ? {alu_res[0:29], 2'b00} : 32'd0;
  assign dmem.dmem_be    = req ? lane_be : 4'b0000;
  assign dmem.dmem_wdata = (req & is_store) ? (in_wait ? wdata_q : lane_wdata) : 32'd0;

  assign mis_flag = is_mem & ~trap & misaligned;
  assign rw_out   = reg_write & ~trap & ~mis_flag & ~timed_out;
  assign ld_out   = (is_load & done_ack) ? load_data : 32'd0;
  assign memwb_d  = {next_pc, alu_res, ld_out, dest_reg, rw_out, mem_to_reg,
                     pc_to_reg, trap, mis_flag, timed_out};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
      wdata_q <= 32'd0;
      memwb_q <= '0;
    end else begin
      memwb_q <= stall ? '0 : memwb_d;
      case (state_q)
        IDLE: begin
          if (access && !dmem.dmem_ack) begin
            state_q <= WAIT;
            cnt_q   <= 8'd1;
            wdata_q <= lane_wdata;
          end
        end
        WAIT: begin
          if (dmem.dmem_ack || timed_out) begin
            state_q <= IDLE;
            cnt_q   <= 8'd0;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign memwb_out = memwb_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: directed vector table, reset-abort sequence and
// randomized instructions checked against a behavioural model.
module tb_mem_access_stage;
  localparam int TO = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic [0:179] exmem_in;
  logic         wb_regwrite;
  logic [0:4]   wb_dest;
  logic [0:31]  wb_value;
  logic         stall;
  logic [0:106] memwb_out;

  mem_access_stage_if dmem_if();

  mem_access_stage #(.TIMEOUT(TO)) dut (
    .clk        (clk),
    .reset      (reset),
    .exmem_in   (exmem_in),
    .wb_regwrite(wb_regwrite),
    .wb_dest    (wb_dest),
    .wb_value   (wb_value),
    .dmem       (dmem_if.master),
    .stall      (stall),
    .memwb_out  (memwb_out)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [31:0] pc, alu, memval;
    logic [4:0]  dest, rs2;
    logic        rw, mtr, mw, ls, pctoreg, trap;
    logic [1:0]  dsize;
  } instr_t;

  typedef struct {
    instr_t      in;
    logic        wbrw;
    logic [4:0]  wbd;
    logic [31:0] wbv;
    int          lat;
    logic [31:0] rdata;
  } stim_t;

  typedef struct {
    logic        acc, we;
    logic [31:0] addr, wdata;
    logic [3:0]  be;
    int          nstall;
    logic [31:0] ld;
    logic        rw, mis, berr;
  } exp_t;

  typedef struct {
    stim_t s;
    exp_t  e;
  } vec_t;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic instr_t ins(logic mw, logic mtr, logic ls, logic [1:0] dsize,
                                 logic [31:0] alu, logic [31:0] memval, logic rw,
                                 logic trap, logic [4:0] rs2);
    instr_t i;
    i.pc = 32'h1000 + alu; i.alu = alu; i.memval = memval; i.dest = 5'd7; i.rs2 = rs2;
    i.rw = rw; i.mtr = mtr; i.mw = mw; i.ls = ls; i.pctoreg = 1'b0; i.trap = trap;
    i.dsize = dsize;
    return i;
  endfunction

  function automatic stim_t st(instr_t i, logic wbrw, logic [4:0] wbd, logic [31:0] wbv,
                               int lat, logic [31:0] rdata);
    stim_t s;
    s.in = i; s.wbrw = wbrw; s.wbd = wbd; s.wbv = wbv; s.lat = lat; s.rdata = rdata;
    return s;
  endfunction

  function automatic exp_t ex(logic acc, logic we, logic [31:0] addr, logic [3:0] be,
                              logic [31:0] wdata, int nstall, logic [31:0] ld,
                              logic rw, logic mis, logic berr);
    exp_t e;
    e.acc = acc; e.we = we; e.addr = addr; e.be = be; e.wdata = wdata;
    e.nstall = nstall; e.ld = ld; e.rw = rw; e.mis = mis; e.berr = berr;
    return e;
  endfunction

  function automatic logic [0:179] pack_ex(instr_t i);
    logic [0:179] x;
    x = '0;
    x[0:31]    = i.pc;
    x[32:63]   = ~i.alu;
    x[64:68]   = i.dest;
    x[69:100]  = i.alu;
    x[101]     = i.pctoreg;
    x[102]     = 1'b1;
    x[103]     = i.rw;
    x[104]     = i.mtr;
    x[105]     = i.mw;
    x[106]     = i.ls;
    x[107:108] = i.dsize;
    x[109:140] = i.pc ^ 32'h5A5A_5A5A;
    x[141]     = 1'b1;
    x[142:173] = i.memval;
    x[174:178] = i.rs2;
    x[179]     = i.trap;
    return x;
  endfunction

  // Reference behaviour expressed with sizes in bytes and numeric shifts
  function automatic exp_t model(stim_t s);
    exp_t e;
    int sz, off;
    logic [31:0] d, v, mask;
    bit store, load, mem, mis, berr;
    store = s.in.mw;
    load  = s.in.mtr && !s.in.mw;
    mem   = store || load;
    sz    = (s.in.dsize == 2'd0) ? 1 : (s.in.dsize == 2'd1) ? 2 : 4;
    off   = int'(s.in.alu % 32'd4);
    mis   = mem && !s.in.trap && ((off % sz) != 0);
    e.acc = mem && !s.in.trap && !mis;
    e.we  = e.acc && store;
    e.addr = e.acc ? s.in.alu - 32'(off) : 32'd0;
    e.be = 4'b0000;
    if (e.acc)
      for (int i = 0; i < 4; i++)
        if (i >= off && i < off + sz) e.be = e.be | 4'(1 << (3 - i));
    d = (s.wbrw && s.wbd == s.in.rs2 && s.in.rs2 != 5'd0) ? s.wbv : s.in.memval;
    e.wdata = 32'd0;
    if (e.we) begin
      if (sz == 1)      e.wdata = (d & 32'hFF) * 32'h0101_0101;
      else if (sz == 2) e.wdata = (d & 32'hFFFF) * 32'h0001_0001;
      else              e.wdata = d;
    end
    berr     = e.acc && (s.lat > TO);
    e.nstall = !e.acc ? 0 : ((s.lat > TO) ? TO : s.lat);
    e.ld = 32'd0;
    if (load && e.acc && !berr) begin
      mask = (sz == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * sz)) - 32'd1);
      v = (s.rdata >> (8 * (4 - off - sz))) & mask;
      if (s.in.ls && sz < 4 && v[8 * sz - 1]) v = v | ~mask;
      e.ld = v;
    end
    e.rw   = s.in.rw && !s.in.trap && !mis && !berr;
    e.mis  = mis;
    e.berr = berr;
    return e;
  endfunction

  function automatic logic [0:106] build_wb(stim_t s, exp_t e);
    logic [0:106] w;
    w = '0;
    w[0:31]   = s.in.pc;
    w[32:63]  = s.in.alu;
    w[64:95]  = e.ld;
    w[96:100] = s.in.dest;
    w[101]    = e.rw;
    w[102]    = s.in.mtr;
    w[103]    = s.in.pctoreg;
    w[104]    = s.in.trap;
    w[105]    = e.mis;
    w[106]    = e.berr;
    return w;
  endfunction

  // Applies one instruction after a rising edge and returns just after its completion edge
  task automatic run(input stim_t s, input exp_t e, input string nm);
    exmem_in          = pack_ex(s.in);
    wb_regwrite       = s.wbrw;
    wb_dest           = s.wbd;
    wb_value          = s.wbv;
    dmem_if.dmem_rdata = s.rdata;
    for (int c = 0; c <= e.nstall; c++) begin
      dmem_if.dmem_ack = e.acc ? (c == s.lat) : 1'($urandom_range(0, 1));
      if (c >= 1) wb_value = ~s.wbv;
      @(negedge clk);
      chk({nm, " req"}, dmem_if.dmem_req, e.acc);
      chk({nm, " stall"}, stall, (c < e.nstall));
      if (e.acc) begin
        chk({nm, " we"}, dmem_if.dmem_we, e.we);
        chk({nm, " addr"}, dmem_if.dmem_addr, e.addr);
        chk({nm, " be"}, dmem_if.dmem_be, e.be);
        chk({nm, " wdata"}, dmem_if.dmem_wdata, e.wdata);
      end
      if (c >= 1) chk({nm, " bubble"}, memwb_out, 107'd0);
      @(posedge clk);
      #1;
    end
    dmem_if.dmem_ack = 1'b0;
    chk({nm, " memwb"}, memwb_out, build_wb(s, e));
  endtask

  vec_t  tbl [11];
  stim_t rs;
  instr_t ri;
  int     kind;

  initial begin
    tbl[0]  = '{st(ins(1,0,0,2'd2,32'h100,32'hDEADBEEF,0,0,5'd0),0,5'd0,32'h0,0,32'h0),
                ex(1,1,32'h100,4'b1111,32'hDEADBEEF,0,32'h0,0,0,0)};
    tbl[1]  = '{st(ins(0,1,1,2'd0,32'h203,32'h0,1,0,5'd0),0,5'd0,32'h0,3,32'h112233F0),
                ex(1,0,32'h200,4'b0001,32'h0,3,32'hFFFFFFF0,1,0,0)};
    tbl[2]  = '{st(ins(0,1,0,2'd1,32'h202,32'h0,1,0,5'd0),0,5'd0,32'h0,1,32'h1234ABCD),
                ex(1,0,32'h200,4'b0011,32'h0,1,32'h0000ABCD,1,0,0)};
    tbl[3]  = '{st(ins(0,1,0,2'd2,32'h101,32'h0,1,0,5'd0),0,5'd0,32'h0,0,32'h0),
                ex(0,0,32'h0,4'b0000,32'h0,0,32'h0,0,1,0)};
    tbl[4]  = '{st(ins(1,0,0,2'd0,32'h301,32'h12345678,0,0,5'd5),1,5'd5,32'hAA,0,32'h0),
                ex(1,1,32'h300,4'b0100,32'hAAAAAAAA,0,32'h0,0,0,0)};
    tbl[5]  = '{st(ins(0,1,0,2'd2,32'h400,32'h0,1,0,5'd0),0,5'd0,32'h0,99,32'h55555555),
                ex(1,0,32'h400,4'b1111,32'h0,4,32'h0,0,0,1)};
    tbl[6]  = '{st(ins(0,1,0,2'd2,32'h404,32'h0,1,1,5'd0),0,5'd0,32'h0,0,32'h0),
                ex(0,0,32'h0,4'b0000,32'h0,0,32'h0,0,0,0)};
    tbl[7]  = '{st(ins(0,0,0,2'd0,32'h1234,32'h0,1,0,5'd0),0,5'd0,32'h0,0,32'h0),
                ex(0,0,32'h0,4'b0000,32'h0,0,32'h0,1,0,0)};
    tbl[8]  = '{st(ins(1,1,0,2'd1,32'h502,32'h0000BEEF,0,0,5'd0),0,5'd0,32'h0,2,32'h0),
                ex(1,1,32'h500,4'b0011,32'hBEEFBEEF,2,32'h0,0,0,0)};
    tbl[9]  = '{st(ins(1,0,0,2'd2,32'h600,32'h01020304,0,0,5'd0),1,5'd0,32'hFFFFFFFF,0,32'h0),
                ex(1,1,32'h600,4'b1111,32'h01020304,0,32'h0,0,0,0)};
    tbl[10] = '{st(ins(0,1,1,2'd1,32'h700,32'h0,1,0,5'd0),0,5'd0,32'h0,4,32'h80010000),
                ex(1,0,32'h700,4'b1100,32'h0,4,32'hFFFF8001,1,0,0)};

    reset = 1'b1;
    exmem_in = '0;
    wb_regwrite = 1'b0;
    wb_dest = '0;
    wb_value = '0;
    dmem_if.dmem_ack = 1'b0;
    dmem_if.dmem_rdata = '0;
    #2;
    chk("reset memwb", memwb_out, 107'd0);
    exmem_in = pack_ex(tbl[0].s.in);
    #1;
    chk("reset req", dmem_if.dmem_req, 1'b0);
    chk("reset stall", stall, 1'b0);
    chk("reset we", dmem_if.dmem_we, 1'b0);
    exmem_in = '0;
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;

    for (int k = 0; k < 11; k++) run(tbl[k].s, tbl[k].e, $sformatf("vec%0d", k));

    // Reset while waiting must abandon the access at once
    rs = st(ins(0,1,0,2'd2,32'h800,32'h0,1,0,5'd0),0,5'd0,32'h0,99,32'h0);
    exmem_in = pack_ex(rs.in);
    dmem_if.dmem_ack = 1'b0;
    @(negedge clk);
    chk("abort req issue", dmem_if.dmem_req, 1'b1);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("abort stall wait", stall, 1'b1);
    #1;
    reset = 1'b1;
    #1;
    chk("abort req", dmem_if.dmem_req, 1'b0);
    chk("abort stall", stall, 1'b0);
    chk("abort memwb", memwb_out, 107'd0);
    exmem_in = '0;
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("abort after", memwb_out, 107'd0);

    for (int n = 0; n < 200; n++) begin
      kind       = $urandom_range(0, 3);
      ri.mw      = (kind >= 2);
      ri.mtr     = (kind == 1) || (kind == 3);
      ri.ls      = 1'($urandom_range(0, 1));
      ri.dsize   = 2'($urandom_range(0, 3));
      ri.alu     = $urandom & 32'h0000_0FFF;
      ri.pc      = $urandom;
      ri.memval  = $urandom;
      ri.dest    = 5'($urandom_range(0, 31));
      ri.rs2     = 5'($urandom_range(0, 3));
      ri.rw      = 1'($urandom_range(0, 1));
      ri.pctoreg = 1'($urandom_range(0, 1));
      ri.trap    = ($urandom_range(0, 7) == 0);
      rs = st(ri, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), $urandom,
              $urandom_range(0, 6), $urandom);
      run(rs, model(rs), $sformatf("rnd%0d", n));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_access_stage.md
# mem_access_stage

Memory-stage controller of the five-stage pipeline. It consumes the 180-bit EX/MEM bundle, performs the load or store against the data memory with a req/ack handshake, and stalls the front of the pipe while the access is outstanding. It formats sub-word data in big-endian order and produces the registered 107-bit MEM/WB bundle for writeback.

## Interface
- `TIMEOUT`, 255: maximum number of wait cycles before an access is aborted with a bus error (range 1–255).
- `clk` in 1: single pipeline clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `exmem_in` in [0:179]: EX/MEM bundle.
  - nextPC [0:31], opB [32:63], destReg [64:68], aluResult [69:100] (effective address).
  - PCtoReg [101], RegToPC [102], RegWrite [103], MemToReg [104] (load), MemWrite [105] (store).
  - loadSign [106], DSize [107:108], leapAddr [109:140], leap [141], memVal [142:173] (store data), rs2 [174:178], trap [179].
- `wb_regwrite` in 1, `wb_dest` in [0:4], `wb_value` in [0:31]: the writeback-stage write port, used for store-data forwarding.
- `dmem_req` out 1: access request.
- `dmem_we` out 1: 1 = write.
- `dmem_addr` out [0:31]: word-aligned address.
- `dmem_be` out [0:3]: byte enables; `be[i]` covers data bits [8i:8i+7].
- `dmem_wdata` out [0:31]: write data.
- `dmem_rdata` in [0:31]: read data, valid in the same cycle as `dmem_ack`.
- `dmem_ack` in 1: access complete.
- `stall` out 1: freezes the PC, IF/ID, ID/EX and EX/MEM registers.
- `memwb_out` out [0:106]: registered MEM/WB bundle.
  - nextPC [0:31], aluResult [32:63], loadData [64:95], destReg [96:100].
  - RegWrite [101], MemToReg [102], PCtoReg [103], trap [104], misalign [105], bus_err [106].

## Operation
- **Access type.** MemWrite=1 makes the instruction a store. MemToReg=1 with MemWrite=0 makes it a load. If both are 1, the instruction is treated as a store.
- **Sizes.** DSize 00 = byte, 01 = halfword, 10 or 11 = word. The byte offset is `off = aluResult[30:31]`.
- **Alignment.** Halfword requires off[1]=0; word requires off=00. A misaligned access:
  - issues no request and does not stall;
  - writes memwb_out with misalign=1 and RegWrite=0.
- **Traps.** trap=1 suppresses any access. The bundle passes through with trap=1 and RegWrite=0.
- **Store-data forwarding.** If wb_regwrite=1, wb_dest=rs2 and rs2≠0, the store data is wb_value; otherwise it is memVal.
- **Store lanes.**
  - Byte: data replicated in all four lanes; be one-hot at index off.
  - Halfword: data replicated in both halves; be=1100 for off=0, 0011 for off=2.
  - Word: be=1111.
- **Load formatting.**
  - Byte: rdata[8·off : 8·off+7].
  - Halfword: rdata[0:15] for off=0, rdata[16:31] for off=2.
  - Word: rdata unchanged.
  - Loaded bytes/halfwords are right-justified; the upper bits are sign-extended when loadSign=1, else zero-filled.
  - Stores and non-memory instructions produce loadData = 0.
- **dmem_addr** = {aluResult[0:29], 00}.
- **FSM states:** IDLE, WAIT.
  - IDLE, aligned memory op, no trap: dmem_req=1 combinationally.
    - If dmem_ack=1 in the same cycle, the access completes at this edge with zero stall.
    - Otherwise stall=1 and the FSM enters WAIT with the wait counter at 1.
  - WAIT: dmem_req, dmem_we, address, be and wdata are held (EX/MEM is frozen by stall) and stall=1.
    - On dmem_ack: stall=0 in that cycle and the access completes at the edge. Next state is IDLE.
    - When the counter reaches TIMEOUT with no ack: the access completes with bus_err=1 and RegWrite=0. Next state is IDLE.
    - Otherwise the counter increments.
  - A non-memory op in IDLE passes straight through with no request.
- **Stalled cycles.** While stall=1, memwb_out loads a bubble (all zero) each edge. The instruction's bundle is written only at its completion edge.
- **Acks outside WAIT.** dmem_ack while dmem_req=0 is ignored.

## Timing
- **Reset:** state=IDLE, counter=0, memwb_out=0, memory outputs low.
  - dmem_req, dmem_we, dmem_be and stall are combinational from state and exmem_in; under reset they are forced to 0 immediately.
  - Reset during WAIT abandons the access.
- **Latency.** The bundle is visible on memwb_out one edge after completion.
  - Zero-wait access: 1 cycle total.
  - N-wait access: stall is high for N cycles.
- **Request pulse.** dmem_req stays high through the ack cycle and drops the next cycle unless the following instruction is also a memory op, giving back-to-back accesses with no idle gap.
- **Forwarding timing.** The forwarding compare uses wb_* values current in the cycle the request is issued.

## Test plan
- **Zero-wait word store.** Store word, aluResult=0x100, memVal=0xDEADBEEF, ack same cycle → one request with addr=0x100, be=1111, wdata=0xDEADBEEF, we=1; stall never asserted.
- **Signed byte load with waits.** Byte load, loadSign=1, aluResult=0x203, rdata=0x112233F0, ack after 3 cycles → stall high 3 cycles; memwb loadData=0xFFFFFFF0, RegWrite=1; bubbles before it.
- **Unsigned halfword load.** loadSign=0, aluResult=0x202, rdata=0x1234ABCD → loadData=0x0000ABCD.
- **Misaligned word.** aluResult=0x101 → no dmem_req, misalign=1, RegWrite=0, no stall.
- **Forwarded byte store.** rs2=5, wb_dest=5, wb_regwrite=1, wb_value=0x000000AA, off=1 → wdata=0xAAAAAAAA, be=0100.
- **Timeout and reset abort.**
  - TIMEOUT=4, never ack → bus_err=1 after 4 stall cycles.
  - Separately, reset asserted during WAIT → dmem_req and stall drop immediately; memwb_out=0.
